// File: rtl/alu_pipe_hs.sv
// alu_pipe_hs: two-stage pipelined ALU with valid/ready handshake on both sides and a pass-through tag
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (opcode, input1, input2, shiftValue, in_tag)
//   out_valid / out_ready result handshake (result, out_tag, carry/zero/neg/ovf/err flags)
// Stage 1 registers the request, stage 2 registers the computed result and flags.
// Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 SLTU, 4 XOR, 5 AND, 6 OR, 7 SLL, 8 SRL, 9 SRA, 10 SLT,
// 11-15 illegal (result 0, zeroFlag 1, errFlag 1).
module alu_pipe_hs #(
   parameter int WIDTH   = 8,
   parameter int TAG_W   = 4,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   input1,
   input  logic [WIDTH-1:0]   input2,
   input  logic [SHAMT_W-1:0] shiftValue,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [TAG_W-1:0]   out_tag,
   output logic               carryFlag,
   output logic               zeroFlag,
   output logic               negFlag,
   output logic               ovfFlag,
   output logic               errFlag
);
   localparam int LW = $clog2(WIDTH);
   logic               s1_valid, s2_valid, adv1, adv2;
   logic [3:0]         s1_op;
   logic [WIDTH-1:0]   s1_a, s1_b;
   logic [LW-1:0]      s1_sh;
   logic [TAG_W-1:0]   s1_tag;
   logic [WIDTH:0]     sum, diff, sll_x, srl_x;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res;
   logic               c, v, e;
   logic               unused_sh;
   // only the low LW bits of the shift amount matter
   assign unused_sh = ^shiftValue;
   assign adv2      = !s2_valid | out_ready;
   assign adv1      = !s1_valid | adv2;
   assign in_ready  = adv1 & rst_n;
   assign out_valid = s2_valid;
   always_comb begin
      sum   = {1'b0, s1_a} + {1'b0, s1_b};
      diff  = {1'b0, s1_a} - {1'b0, s1_b};
      prod  = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
      // the extra bit of each widened shift captures the last bit shifted out
      sll_x = {1'b0, s1_a} << s1_sh;
      srl_x = {s1_a, 1'b0} >> s1_sh;
      res   = '0;
      c     = 1'b0;
      v     = 1'b0;
      e     = 1'b0;
      case (s1_op)
         4'd0: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
         end
         4'd1: begin
            res = diff[WIDTH-1:0];
            c   = diff[WIDTH];
            v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
         end
         4'd2: begin
            res = prod[WIDTH-1:0];
            c   = |prod[2*WIDTH-1:WIDTH];
         end
         4'd3: begin
            res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            c   = diff[WIDTH];
         end
         4'd4: res = s1_a ^ s1_b;
         4'd5: res = s1_a & s1_b;
         4'd6: res = s1_a | s1_b;
         4'd7: begin
            res = sll_x[WIDTH-1:0];
            c   = sll_x[WIDTH];
         end
         4'd8: begin
            res = srl_x[WIDTH:1];
            c   = srl_x[0];
         end
         4'd9: begin
            res = $signed(s1_a) >>> s1_sh;
            c   = srl_x[0];
         end
         4'd10: res = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
         default: e = 1'b1;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_sh     <= '0;
         s1_tag    <= '0;
         s2_valid  <= 1'b0;
         result    <= '0;
         out_tag   <= '0;
         carryFlag <= 1'b0;
         zeroFlag  <= 1'b0;
         negFlag   <= 1'b0;
         ovfFlag   <= 1'b0;
         errFlag   <= 1'b0;
      end else begin
         if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op  <= opcode;
               s1_a   <= input1;
               s1_b   <= input2;
               s1_sh  <= shiftValue[LW-1:0];
               s1_tag <= in_tag;
            end
         end
         // illegal ops leave res at 0, so zero=1 and neg=0 fall out naturally
         if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               result    <= res;
               out_tag   <= s1_tag;
               carryFlag <= c;
               zeroFlag  <= res == '0;
               negFlag   <= res[WIDTH-1];
               ovfFlag   <= v;
               errFlag   <= e;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_pipe_hs.sv
// tb_alu_pipe_hs: self-checking bench for alu_pipe_hs (WIDTH=8) with directed vectors,
// stall/reset sequences and randomized traffic against an arithmetic reference model
module tb_alu_pipe_hs;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] opcode = '0;
   logic [7:0] input1 = '0;
   logic [7:0] input2 = '0;
   logic [4:0] shiftValue = '0;
   logic [3:0] in_tag = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic [3:0] out_tag;
   logic       carryFlag, zeroFlag, negFlag, ovfFlag, errFlag;

   alu_pipe_hs #(.WIDTH(8), .TAG_W(4), .SHAMT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .out_tag(out_tag), .carryFlag(carryFlag), .zeroFlag(zeroFlag), .negFlag(negFlag),
      .ovfFlag(ovfFlag), .errFlag(errFlag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] sh;
      logic [3:0] tag;
      logic [7:0] res;
      logic [4:0] f;
   } vec_t;

   localparam int NV = 19;
   vec_t        vt[NV];
   int          tests = 0;
   int          fails = 0;
   int          n_out = 0;
   logic [16:0] q[$];
   logic        held_pending = 1'b0;
   logic [17:0] held_val;
   logic        last_ir;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // {result, tag, carry, zero, neg, ovf, err} from plain integer arithmetic
   function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a8,
                                         input logic [7:0] b8, input logic [4:0] sh,
                                         input logic [3:0] tag);
      int a, b, sa, sb, r, k;
      bit c, v, e;
      a  = int'(a8);
      b  = int'(b8);
      sa = a >= 128 ? a - 256 : a;
      sb = b >= 128 ? b - 256 : b;
      k  = int'(sh) % 8;
      r  = 0;
      c  = 0;
      v  = 0;
      e  = 0;
      case (op)
         4'd0: begin r = a + b; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
         4'd1: begin r = a - b; c = a < b; v = (sa - sb > 127) || (sa - sb < -128); end
         4'd2: begin r = a * b; c = r > 255; end
         4'd3: begin r = (a < b) ? 1 : 0; c = a < b; end
         4'd4: r = a ^ b;
         4'd5: r = a & b;
         4'd6: r = a | b;
         4'd7: begin r = a << k; c = ((r >> 8) & 1) != 0; end
         4'd8: begin r = a >> k; c = (((a << 1) >> k) & 1) != 0; end
         4'd9: begin r = sa >>> k; c = (((a << 1) >> k) & 1) != 0; end
         4'd10: r = (sa < sb) ? 1 : 0;
         default: e = 1;
      endcase
      r = r & 255;
      return {r[7:0], tag, c, r == 0, r >= 128, v, e};
   endfunction

   // one clock cycle of handshake traffic, checked against the scoreboard
   task automatic step(input logic iv, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [4:0] sh, input logic [3:0] tag,
                       input logic ordy, output logic acc);
      logic [16:0] got;
      @(negedge clk);
      got = {result, out_tag, carryFlag, zeroFlag, negFlag, ovfFlag, errFlag};
      if (held_pending) chk("hold", {out_valid, got}, held_val);
      in_valid   = iv;
      opcode     = op;
      input1     = a;
      input2     = b;
      shiftValue = sh;
      in_tag     = tag;
      out_ready  = ordy;
      #1;
      last_ir = in_ready;
      acc     = iv && in_ready;
      if (out_valid && out_ready) begin
         n_out++;
         if (q.size() == 0) chk("spurious_out", {15'd0, got}, 32'h1ffff);
         else chk("beat", {15'd0, got}, {15'd0, q.pop_front()});
      end
      held_pending = out_valid && !out_ready;
      held_val     = {out_valid, got};
      if (acc) q.push_back(model(op, a, b, sh, tag));
   endtask

   initial begin
      logic       acc;
      logic [3:0] next_tag;
      int         low_cnt, n0;
      vt[0]  = '{4'd0,  8'hFF, 8'h01, 5'd0, 4'd1, 8'h00, 5'b11000};
      vt[1]  = '{4'd1,  8'h80, 8'h01, 5'd0, 4'd2, 8'h7F, 5'b00010};
      vt[2]  = '{4'd2,  8'h10, 8'h10, 5'd0, 4'd3, 8'h00, 5'b11000};
      vt[3]  = '{4'd3,  8'h01, 8'hFF, 5'd0, 4'd4, 8'h01, 5'b10000};
      vt[4]  = '{4'd10, 8'h01, 8'hFF, 5'd0, 4'd6, 8'h00, 5'b01000};
      vt[5]  = '{4'd7,  8'h81, 8'h00, 5'd1, 4'd7, 8'h02, 5'b10000};
      vt[6]  = '{4'd9,  8'h80, 8'h00, 5'd3, 4'd8, 8'hF0, 5'b00100};
      vt[7]  = '{4'd8,  8'h01, 8'h00, 5'd9, 4'd9, 8'h00, 5'b11000};
      vt[8]  = '{4'd15, 8'h12, 8'h34, 5'd2, 4'd5, 8'h00, 5'b01001};
      vt[9]  = '{4'd4,  8'hA5, 8'h5A, 5'd0, 4'hA, 8'hFF, 5'b00100};
      vt[10] = '{4'd5,  8'hF0, 8'h3C, 5'd0, 4'hB, 8'h30, 5'b00000};
      vt[11] = '{4'd6,  8'hF0, 8'h0F, 5'd0, 4'hC, 8'hFF, 5'b00100};
      vt[12] = '{4'd0,  8'h7F, 8'h01, 5'd0, 4'hD, 8'h80, 5'b00110};
      vt[13] = '{4'd1,  8'h00, 8'h01, 5'd0, 4'hE, 8'hFF, 5'b10100};
      vt[14] = '{4'd7,  8'h01, 8'h00, 5'd0, 4'hF, 8'h01, 5'b00000};
      vt[15] = '{4'd2,  8'h0F, 8'h11, 5'd0, 4'h0, 8'hFF, 5'b00100};
      vt[16] = '{4'd8,  8'h80, 8'h00, 5'd7, 4'h1, 8'h01, 5'b00000};
      vt[17] = '{4'd10, 8'h80, 8'h01, 5'd0, 4'h2, 8'h01, 5'b00000};
      vt[18] = '{4'd1,  8'h01, 8'h80, 5'd0, 4'h3, 8'h81, 5'b10110};
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outs", {out_valid, result, out_tag, carryFlag, zeroFlag, negFlag, ovfFlag, errFlag}, 0);
      rst_n = 1'b1;
      #1 chk("in_ready_after_rst", in_ready, 1);
      // directed vectors, one beat at a time with two-cycle latency
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         opcode     = vt[i].op;
         input1     = vt[i].a;
         input2     = vt[i].b;
         shiftValue = vt[i].sh;
         in_tag     = vt[i].tag;
         out_ready  = 1'b1;
         #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("v%0d_early", i), out_valid, 0);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_result", i), result, vt[i].res);
         chk($sformatf("v%0d_flags", i), {carryFlag, zeroFlag, negFlag, ovfFlag, errFlag}, vt[i].f);
         chk($sformatf("v%0d_tag", i), out_tag, vt[i].tag);
      end
      // stream tags 1..6 with out_ready dropped in cycles 3-5
      held_pending = 1'b0;
      next_tag = 4'd1;
      low_cnt  = 0;
      n0       = n_out;
      for (int cyc = 0; cyc < 20; cyc++) begin
         step(next_tag <= 4'd6, 4'd0, {next_tag, 4'h3}, {4'h0, next_tag}, 5'd0, next_tag,
              !(cyc >= 3 && cyc <= 5), acc);
         if (!last_ir) low_cnt++;
         if (acc) next_tag++;
      end
      chk("stall_in_ready_low", low_cnt > 0, 1);
      chk("stall_all_out", n_out - n0, 6);
      chk("stall_q_empty", q.size(), 0);
      // reset with two beats in flight
      step(1'b1, 4'd0, 8'h01, 8'h02, 5'd0, 4'h7, 1'b1, acc);
      step(1'b1, 4'd4, 8'h03, 8'h04, 5'd0, 4'h8, 1'b1, acc);
      @(negedge clk);
      chk("inflight_valid", out_valid, 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1 chk("rst2_in_ready", in_ready, 0);
      @(negedge clk);
      chk("rst2_outs", {out_valid, result, out_tag, carryFlag, zeroFlag, negFlag, ovfFlag, errFlag}, 0);
      q.delete();
      held_pending = 1'b0;
      rst_n = 1'b1;
      #1 chk("rst2_in_ready_back", in_ready, 1);
      n0 = n_out;
      for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 8'h00, 8'h00, 5'd0, 4'h0, 1'b1, acc);
      chk("rst2_no_ghost", n_out - n0, 0);
      // randomized traffic with random backpressure
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 8'($urandom),
              8'($urandom), 5'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 8'h00, 8'h00, 5'd0, 4'h0, 1'b1, acc);
      chk("rand_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
